// File: rtl/lsu_defs_pkg.sv
`default_nettype none
//==============================================================================
// Module   : lsu_defs (package)
// Desc     : Shared encodings for the memory-stage load/store unit.
// Revision : 1.0 - initial release
//==============================================================================
package lsu_defs;

    localparam logic [3:0] c_LS_LW  = 4'b0001;
    localparam logic [3:0] c_LS_LH  = 4'b0010;
    localparam logic [3:0] c_LS_LHU = 4'b0011;
    localparam logic [3:0] c_LS_LB  = 4'b0100;
    localparam logic [3:0] c_LS_LBU = 4'b0101;
    localparam logic [3:0] c_LS_SW  = 4'b0110;
    localparam logic [3:0] c_LS_SH  = 4'b0111;
    localparam logic [3:0] c_LS_SB  = 4'b1000;

    localparam logic [4:0] c_EXC_ADEL = 5'd4;
    localparam logic [4:0] c_EXC_ADES = 5'd5;
    localparam logic [4:0] c_EXC_DBE  = 5'd7;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_BUSY = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    function automatic logic f_isLoad(input logic [3:0] op);
        return (op >= c_LS_LW) && (op <= c_LS_LBU);
    endfunction

    function automatic logic f_isStore(input logic [3:0] op);
        return (op >= c_LS_SW) && (op <= c_LS_SB);
    endfunction

endpackage
`default_nettype wire

// File: rtl/m_load_ext.sv
`default_nettype none
//==============================================================================
// Module   : m_load_ext
// Desc     : Selects the addressed halfword/byte of a load word and extends it.
// Revision : 1.0 - initial release
//==============================================================================
module m_load_ext
    import lsu_defs::*;
(
    input  logic [31:0] rdata,
    input  logic [3:0]  op,
    input  logic [1:0]  addrLo,
    output logic [31:0] extData
);

    logic [15:0] w_half;
    logic [31:0] w_shifted;
    logic [7:0]  w_byte;

    always_comb begin
        w_half    = addrLo[1] ? rdata[31:16] : rdata[15:0];
        w_shifted = rdata >> {addrLo, 3'b000};
        w_byte    = w_shifted[7:0];
        case (op)
            c_LS_LH:  extData = {{16{w_half[15]}}, w_half};
            c_LS_LHU: extData = {16'h0000, w_half};
            c_LS_LB:  extData = {{24{w_byte[7]}}, w_byte};
            c_LS_LBU: extData = {24'h000000, w_byte};
            default:  extData = rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/m_lsu_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : m_lsu_ctrl
// Desc     : Memory-stage load/store unit with bus handshake, address checks,
//            bus timeout and registered load extension.
// Revision : 1.0 - initial release
//==============================================================================
module m_lsu_ctrl
    import lsu_defs::*;
#(
    parameter logic [31:0] DM_BASE = 32'h0000_0000,
    parameter logic [31:0] DM_SIZE = 32'h0000_3000,
    parameter int          TIMEOUT = 16,
    parameter int          CNT_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [3:0]  lsOp_M,
    input  logic [31:0] addr_M,
    input  logic [31:0] wdata_M,
    input  logic        flush,
    output logic        stall_M,
    output logic        done,
    output logic [31:0] readData_M,
    output logic        exc_valid,
    output logic [4:0]  exc_code,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_byteen,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam logic [CNT_W-1:0] c_TO_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_kill;
    logic [3:0]       r_op;
    logic [1:0]       r_addrLo;
    logic [31:0]      r_busAddr;
    logic             r_busWe;
    logic [3:0]       r_byteen;
    logic [31:0]      r_wdata;
    logic [31:0]      r_readData;

    logic        w_misalign;
    logic [31:0] w_offset;
    logic        w_idleReq;
    logic        w_accept;
    logic        w_addrFault;
    logic        w_busy;
    logic        w_killed;
    logic        w_toHit;
    logic        w_busTimeout;
    logic [3:0]  w_byteen;
    logic [31:0] w_wdata;
    logic [31:0] w_extData;
    logic [4:0]  w_excCode;

    always_comb begin
        w_misalign = 1'b0;
        w_byteen   = 4'b0000;
        w_wdata    = 32'h0000_0000;
        case (lsOp_M)
            c_LS_LW, c_LS_SW:           w_misalign = (addr_M[1:0] != 2'b00);
            c_LS_LH, c_LS_LHU, c_LS_SH: w_misalign = addr_M[0];
            default:                    w_misalign = 1'b0;
        endcase
        case (lsOp_M)
            c_LS_SW: begin
                w_byteen = 4'b1111;
                w_wdata  = wdata_M;
            end
            c_LS_SH: begin
                w_byteen = addr_M[1] ? 4'b1100 : 4'b0011;
                w_wdata  = {2{wdata_M[15:0]}};
            end
            c_LS_SB: begin
                w_byteen = 4'b0001 << addr_M[1:0];
                w_wdata  = {4{wdata_M[7:0]}};
            end
            default: begin
                w_byteen = 4'b0000;
                w_wdata  = 32'h0000_0000;
            end
        endcase
    end

    // Offset compare keeps the range check free of a constant lower bound.
    assign w_offset    = addr_M - DM_BASE;
    assign w_idleReq   = (r_state == c_ST_IDLE) && req_valid && !flush
                         && (f_isLoad(lsOp_M) || f_isStore(lsOp_M));
    assign w_addrFault = w_idleReq && (w_misalign || (w_offset >= DM_SIZE));
    assign w_accept    = w_idleReq && !w_addrFault;

    assign w_busy       = (r_state == c_ST_BUSY);
    assign w_killed     = r_kill || flush;
    assign w_toHit      = w_busy && !bus_ack && (r_cnt == c_TO_LAST);
    // A killed instruction never raises the bus error; the transfer just ends.
    assign w_busTimeout = w_toHit && !w_killed;

    always_comb begin
        w_excCode = 5'd0;
        if (w_addrFault)
            w_excCode = f_isLoad(lsOp_M) ? c_EXC_ADEL : c_EXC_ADES;
        else if (w_busTimeout)
            w_excCode = c_EXC_DBE;
    end

    m_load_ext u_loadExt (
        .rdata   (bus_rdata),
        .op      (r_op),
        .addrLo  (r_addrLo),
        .extData (w_extData)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_ST_IDLE;
            r_cnt      <= '0;
            r_kill     <= 1'b0;
            r_op       <= 4'b0000;
            r_addrLo   <= 2'b00;
            r_busAddr  <= 32'h0000_0000;
            r_busWe    <= 1'b0;
            r_byteen   <= 4'b0000;
            r_wdata    <= 32'h0000_0000;
            r_readData <= 32'h0000_0000;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_op      <= lsOp_M;
                        r_addrLo  <= addr_M[1:0];
                        r_busAddr <= {addr_M[31:2], 2'b00};
                        r_busWe   <= f_isStore(lsOp_M);
                        r_byteen  <= w_byteen;
                        r_wdata   <= w_wdata;
                        r_cnt     <= '0;
                        r_kill    <= 1'b0;
                        r_state   <= c_ST_BUSY;
                    end
                end
                c_ST_BUSY: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (flush)
                        r_kill <= 1'b1;
                    if (bus_ack) begin
                        if (!w_killed && f_isLoad(r_op))
                            r_readData <= w_extData;
                        r_state <= w_killed ? c_ST_IDLE : c_ST_DONE;
                    end else if (w_toHit) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                c_ST_DONE: r_state <= c_ST_IDLE;
                default:   r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign stall_M    = w_accept || w_busy;
    assign done       = (r_state == c_ST_DONE);
    assign readData_M = r_readData;
    assign exc_valid  = w_addrFault || w_busTimeout;
    assign exc_code   = w_excCode;
    assign bus_req    = w_busy;
    assign bus_we     = r_busWe;
    assign bus_addr   = r_busAddr;
    assign bus_byteen = r_byteen;
    assign bus_wdata  = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_m_lsu_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : tb_m_lsu_ctrl
// Desc     : Scoreboard bench for m_lsu_ctrl: directed cases plus random ops.
// Revision : 1.0 - initial release
//==============================================================================
module tb_m_lsu_ctrl;

    localparam int          c_TO      = 16;
    localparam logic [31:0] c_DM_BASE = 32'h0000_0000;
    localparam logic [31:0] c_DM_SIZE = 32'h0000_3000;

    typedef struct {
        bit          isExc;
        logic [31:0] val;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic [3:0]  lsOp_M = 4'd0;
    logic [31:0] addr_M = 32'd0;
    logic [31:0] wdata_M = 32'd0;
    logic        flush = 1'b0;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = 32'd0;
    logic        stall_M, done, exc_valid, bus_req, bus_we;
    logic [31:0] readData_M, bus_addr, bus_wdata;
    logic [4:0]  exc_code;
    logic [3:0]  bus_byteen;

    int          vectors = 0;
    int          miscompares = 0;
    ev_t         expQ[$];
    logic [31:0] mReadData = 32'd0;
    bit          expBusValid = 1'b0;
    bit          expWe;
    logic [31:0] expAddr, expWdata;
    logic [3:0]  expByteen;

    m_lsu_ctrl #(
        .DM_BASE (c_DM_BASE),
        .DM_SIZE (c_DM_SIZE),
        .TIMEOUT (c_TO),
        .CNT_W   (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .lsOp_M     (lsOp_M),
        .addr_M     (addr_M),
        .wdata_M    (wdata_M),
        .flush      (flush),
        .stall_M    (stall_M),
        .done       (done),
        .readData_M (readData_M),
        .exc_valid  (exc_valid),
        .exc_code   (exc_code),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_byteen (bus_byteen),
        .bus_wdata  (bus_wdata),
        .bus_ack    (bus_ack),
        .bus_rdata  (bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Access size in bytes, 0 for a no-op encoding.
    function automatic int opSize(input logic [3:0] op);
        case (op)
            4'd1, 4'd6:       return 4;
            4'd2, 4'd3, 4'd7: return 2;
            4'd4, 4'd5, 4'd8: return 1;
            default:          return 0;
        endcase
    endfunction

    function automatic bit isLoadOp(input logic [3:0] op);
        return op >= 4'd1 && op <= 4'd5;
    endfunction

    function automatic bit inRange(input logic [31:0] addr);
        longint a, lo, hi;
        a  = longint'(addr);
        lo = longint'(c_DM_BASE);
        hi = lo + longint'(c_DM_SIZE);
        return (a >= lo) && (a < hi);
    endfunction

    function automatic logic [31:0] modelLoad(input logic [3:0] op, input logic [31:0] addr,
                                              input logic [31:0] rdata);
        int     sz;
        longint v, full;
        sz = opSize(op);
        if (sz == 4) return rdata;
        full = longint'(1) << (8 * sz);
        v    = (longint'(rdata) >> (8 * (addr % 4))) % full;
        if ((op == 4'd2 || op == 4'd4) && v >= full / 2) v = v - full;
        return 32'(v);
    endfunction

    task automatic storeLanes(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                              output logic [3:0] be, output logic [31:0] wd);
        int sz;
        sz = opSize(op);
        be = 4'(((1 << sz) - 1) << (addr % 4));
        for (int i = 0; i < 4; i++) wd[8*i +: 8] = wdata[8*(i % sz) +: 8];
    endtask

    task automatic monitor();
        ev_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (done) begin
                    if (expQ.size() == 0) begin
                        check("unexpected_done", {31'd0, done}, 32'd0);
                    end else begin
                        e = expQ.pop_front();
                        check("done_kind", {31'd0, e.isExc}, 32'd0);
                        check("readData", readData_M, e.val);
                    end
                end
                if (exc_valid) begin
                    if (expQ.size() == 0) begin
                        check("unexpected_exc", {27'd0, exc_code}, 32'd0);
                    end else begin
                        e = expQ.pop_front();
                        check("exc_kind", {31'd0, e.isExc}, 32'd1);
                        check("exc_code", {27'd0, exc_code}, e.val);
                    end
                end
                if (bus_req) begin
                    if (!expBusValid) begin
                        check("unexpected_bus_req", {31'd0, bus_req}, 32'd0);
                    end else begin
                        check("bus_addr", bus_addr, expAddr);
                        check("bus_ctl", {27'd0, bus_we, bus_byteen}, {27'd0, expWe, expByteen});
                        if (expWe) check("bus_wdata", bus_wdata, expWdata);
                    end
                end
            end
        end
    endtask

    task automatic idleCycle();
        bus_ack = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("stall_idle", {31'd0, stall_M}, 32'd0);
        check("readData_hold", readData_M, mReadData);
        @(posedge clk); #1;
        bus_ack = 1'b0;
    endtask

    task automatic runOp(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int ackDelay, input int flushAt,
                         input bit flushIdle);
        int  sz, busyCycles, stallCnt, reqCnt;
        bit  valid, exc, acked, killed;
        ev_t e;
        sz    = opSize(op);
        valid = (sz != 0);
        exc   = valid && ((addr % sz) != 0 || !inRange(addr));
        req_valid = 1'b1; lsOp_M = op; addr_M = addr; wdata_M = wdata;
        flush = flushIdle; bus_ack = 1'($urandom_range(0, 1)); bus_rdata = $urandom;
        if (valid && !flushIdle && exc) begin
            e.isExc = 1'b1;
            e.val   = isLoadOp(op) ? 32'd4 : 32'd5;
            expQ.push_back(e);
        end
        @(negedge clk);
        check("stall_accept", {31'd0, stall_M}, {31'd0, valid && !flushIdle && !exc});
        @(posedge clk); #1;
        req_valid = 1'b0; lsOp_M = 4'd0; flush = 1'b0; bus_ack = 1'b0;
        if (!valid || flushIdle || exc) begin
            idleCycle();
            return;
        end
        expWe   = !isLoadOp(op);
        expAddr = addr & ~32'd3;
        if (expWe) storeLanes(op, addr, wdata, expByteen, expWdata);
        else begin expByteen = 4'd0; expWdata = 32'd0; end
        expBusValid = 1'b1;
        acked      = ackDelay < c_TO;
        killed     = acked && flushAt >= 0 && flushAt <= ackDelay;
        busyCycles = acked ? ackDelay + 1 : c_TO;
        if (acked && !killed) begin
            if (isLoadOp(op)) mReadData = modelLoad(op, addr, rdata);
            e.isExc = 1'b0; e.val = mReadData;
            expQ.push_back(e);
        end else if (!acked) begin
            e.isExc = 1'b1; e.val = 32'd7;
            expQ.push_back(e);
        end
        stallCnt = 0; reqCnt = 0;
        for (int k = 0; k < busyCycles; k++) begin
            bus_ack   = acked && (k == ackDelay);
            bus_rdata = bus_ack ? rdata : $urandom;
            flush     = (k == flushAt);
            @(negedge clk);
            stallCnt += int'(stall_M);
            reqCnt   += int'(bus_req);
            @(posedge clk); #1;
        end
        bus_ack = 1'b0; flush = 1'b0; expBusValid = 1'b0;
        check("stall_busy_cycles", stallCnt, busyCycles);
        check("bus_req_cycles", reqCnt, busyCycles);
        if (acked && !killed) begin
            bus_ack = 1'($urandom_range(0, 1));
            flush   = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("stall_done", {31'd0, stall_M}, 32'd0);
            @(posedge clk); #1;
            bus_ack = 1'b0; flush = 1'b0;
        end
        idleCycle();
    endtask

    initial begin
        fork
            monitor();
            begin
                #1_000_000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1);
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_ctl", {18'd0, stall_M, done, exc_valid, exc_code, bus_req, bus_we, bus_byteen},
              32'd0);
        check("rst_readData", readData_M, 32'd0);
        check("rst_bus_addr", bus_addr, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Directed cases
        runOp(4'd4, 32'h0000_0103, 32'h0, 32'h80FF_0000, 0, -1, 1'b0);
        check("lb_result", readData_M, 32'hFFFF_FF80);
        runOp(4'd7, 32'h0000_0002, 32'h1234_ABCD, 32'h0, 3, -1, 1'b0);
        runOp(4'd1, 32'h0000_0006, 32'h0, 32'h0, 0, -1, 1'b0);
        runOp(4'd6, 32'h0000_3000, 32'h5555_AAAA, 32'h0, 0, -1, 1'b0);
        runOp(4'd3, 32'h0000_0010, 32'h0, 32'h0, c_TO, -1, 1'b0);
        runOp(4'd1, 32'h0000_0040, 32'h0, 32'h1357_9BDF, 3, 1, 1'b0);
        check("flush_keeps_readData", readData_M, 32'hFFFF_FF80);

        // Reset while BUSY
        req_valid = 1'b1; lsOp_M = 4'd1; addr_M = 32'h0000_0020;
        @(posedge clk); #1;
        req_valid = 1'b0; lsOp_M = 4'd0;
        expBusValid = 1'b1; expWe = 1'b0; expAddr = 32'h0000_0020; expByteen = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        expBusValid = 1'b0;
        @(negedge clk);
        check("rst_busy_bus_req", {31'd0, bus_req}, 32'd0);
        check("rst_busy_stall", {31'd0, stall_M}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        mReadData = 32'd0;
        runOp(4'd5, 32'h0000_0000, 32'h0, 32'h0000_00F0, 0, -1, 1'b0);
        check("lbu_after_reset", readData_M, 32'h0000_00F0);

        // Random operations
        for (int n = 0; n < 70; n++) begin
            logic [3:0]  op;
            logic [31:0] addr;
            int          sz, ackD, flAt;
            op   = 4'($urandom_range(0, 15));
            sz   = opSize(op);
            addr = 32'($urandom_range(0, 32'h2FFF));
            if (sz != 0 && $urandom_range(0, 1) == 1) addr = addr & ~32'(sz - 1);
            if ($urandom_range(0, 7) == 0) addr = 32'h0000_3000 + 32'($urandom_range(0, 255));
            ackD = ($urandom_range(0, 9) == 0) ? c_TO : int'($urandom_range(0, 4));
            flAt = (ackD < c_TO && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, ackD)) : -1;
            runOp(op, addr, $urandom, $urandom, ackD, flAt, $urandom_range(0, 9) == 0);
        end

        repeat (2) @(posedge clk);
        #1;
        check("queue_empty", expQ.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
